key_event_ctrl: RTL
===================

KEY_EVENT_CTRL -- requirements
Module: key_event_ctrl

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 4: number of debounced key inputs served.
REQ-002 SHALL have parameter LONG_CYCLES, default 50_000_000: hold cycles from press to LONG event.
REQ-003 SHALL have parameter REPEAT_CYCLES, default 10_000_000: cycles between REPEAT events after LONG.
REQ-004 SHALL have port clk, input, 1: single clock; one clock domain, all logic on rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port key_level, input, NUM_KEYS: debounced key levels, 1 = pressed, synchronous to clk.
REQ-007 SHALL have port evt_valid, output, 1: event word valid.
REQ-008 SHALL have port evt_ready, input, 1: consumer accepts event.
REQ-009 SHALL have port evt_key, output, clog2(NUM_KEYS): index of the key that raised the event.
REQ-010 SHALL have port evt_type, output, 2: event type, PRESS=0, RELEASE=1, LONG=2, REPEAT=3.
REQ-011 SHALL have port overrun, output, 1: sticky flag, an event was dropped.

Function
REQ-012 SHALL register key_level into key_q every cycle; press = key_level & ~key_q, release = ~key_level & key_q, per key.
REQ-013 SHALL run one FSM per key with states IDLE, HELD, LONG_HELD.
REQ-014 IDLE: on press -> HELD, clear hold counter, raise PRESS.
REQ-015 HELD: counter increments each cycle; release -> IDLE with RELEASE; counter == LONG_CYCLES-1 -> LONG_HELD, clear counter, raise LONG.
REQ-016 LONG_HELD: counter increments; release -> IDLE with RELEASE; counter == REPEAT_CYCLES-1 -> clear counter, raise REPEAT, stay.
REQ-017 If release and a counter terminal count occur in the same cycle, the key SHALL raise RELEASE only.
REQ-018 Each key SHALL hold one pending slot (valid bit + type); a raised event loads the slot at the next edge.
REQ-019 If a key raises an event while its slot is still full and the slot is not granted that cycle, the new event SHALL be dropped and overrun set.
REQ-020 An output register SHALL hold one event; it loads when empty or when evt_valid & evt_ready in the same cycle (full throughput, one event per cycle).
REQ-021 Grant SHALL be round-robin over full slots, starting at the index after the last granted key; the granted slot clears on load.
REQ-022 evt_valid, evt_key and evt_type SHALL stay stable while evt_valid & ~evt_ready.
REQ-023 Uncontended latency: evt_valid SHALL rise 2 edges after the edge that first samples the key_level change.
REQ-024 Counters SHALL be clog2(max(LONG_CYCLES, REPEAT_CYCLES)) bits wide; they hold at 0 in IDLE and never wrap.

Reset
REQ-025 On rst, all FSMs SHALL go to IDLE, counters and key_q to 0, slots empty, evt_valid=0, evt_key=0, evt_type=0, overrun=0, round-robin pointer=0.
REQ-026 rst mid-hold SHALL discard all pending events; a key still held after reset SHALL raise PRESS, because key_q resets to 0.

Structure
REQ-027 Event-type encodings and the FSM state encoding SHALL live in shared package key_evt_pkg.
REQ-028 Per-key edge detect, FSM and counter SHALL be sub-module key_track, instantiated NUM_KEYS times; arbitration and the output register stay in key_event_ctrl.

Verification (NUM_KEYS=4, LONG_CYCLES=8, REPEAT_CYCLES=4, evt_ready=1 unless stated)
REQ-029 Key 2 high for 3 cycles -> PRESS(key 2) then RELEASE(key 2), no LONG, overrun=0.
REQ-030 Key 0 held 20 cycles -> PRESS, LONG 8 cycles after PRESS detect, REPEAT every 4 cycles thereafter, then RELEASE.
REQ-031 Keys 0..3 pressed in the same cycle, pointer=0 -> PRESS events out in order key 1, 2, 3, 0 on consecutive cycles.
REQ-032 evt_ready=0 for 10 cycles while key 1 toggles 3 times -> first event held stable, second held in slot, later ones dropped, overrun=1 stays set.
REQ-033 Release on the exact cycle the counter reaches 7 -> RELEASE only, FSM IDLE.
REQ-034 rst pulsed while key 3 is held in LONG_HELD -> all outputs 0 next cycle, then PRESS(key 3) 2 cycles after rst drops.

Source files
------------

// File: rtl/key_evt_pkg.sv
// Shared definitions for the key event controller.
//   evt_type_e  : event type encoding presented on evt_type
//   key_state_e : per-key tracking FSM state encoding
//   evt_slot_t  : per-key pending event slot (valid + type)
//   cnt_width() : hold counter width sized for the longer of the two intervals
package key_evt_pkg;

  typedef enum logic [1:0] {
    EVT_PRESS   = 2'd0,
    EVT_RELEASE = 2'd1,
    EVT_LONG    = 2'd2,
    EVT_REPEAT  = 2'd3
  } evt_type_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_HELD      = 2'd1,
    ST_LONG_HELD = 2'd2
  } key_state_e;

  typedef struct packed {
    logic      valid;
    evt_type_e typ;
  } evt_slot_t;

  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/key_track.sv
// Per-key tracker: edge detect on the debounced level, IDLE/HELD/LONG_HELD
// FSM with hold counter, and a registered one-cycle event pulse.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   i_key_level  : debounced key level, 1 = pressed
//   o_raise      : registered pulse, an event was raised this cycle
//   o_type       : type of the raised event (valid with o_raise)
module key_track
  import key_evt_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000,
  parameter int unsigned CNT_W         = 26
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      i_key_level,
  output logic      o_raise,
  output evt_type_e o_type
);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  logic             r_key_q;
  key_state_e       r_state;
  key_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_raise;
  logic             w_raise_nxt;
  evt_type_e        r_type;
  evt_type_e        w_type_nxt;
  logic             w_press;
  logic             w_release;

  assign w_press   = i_key_level & ~r_key_q;
  assign w_release = ~i_key_level & r_key_q;

  // State register, hold counter and registered event pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_key_q <= 1'b0;
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_raise <= 1'b0;
      r_type  <= EVT_PRESS;
    end else begin
      r_key_q <= i_key_level;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_raise <= w_raise_nxt;
      r_type  <= w_type_nxt;
    end
  end

  // Next state; release is tested before terminal count so it wins a tie
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_raise_nxt = 1'b0;
    w_type_nxt  = EVT_PRESS;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (w_press) begin
          w_state_nxt = ST_HELD;
          w_raise_nxt = 1'b1;
          w_type_nxt  = EVT_PRESS;
        end
      end
      ST_HELD: begin
        if (w_release) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_raise_nxt = 1'b1;
          w_type_nxt  = EVT_RELEASE;
        end else if (r_cnt == LONG_LAST) begin
          w_state_nxt = ST_LONG_HELD;
          w_cnt_nxt   = '0;
          w_raise_nxt = 1'b1;
          w_type_nxt  = EVT_LONG;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_LONG_HELD: begin
        if (w_release) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_raise_nxt = 1'b1;
          w_type_nxt  = EVT_RELEASE;
        end else if (r_cnt == REPEAT_LAST) begin
          w_cnt_nxt   = '0;
          w_raise_nxt = 1'b1;
          w_type_nxt  = EVT_REPEAT;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_raise = r_raise;
  assign o_type  = r_type;

endmodule

// File: rtl/key_event_ctrl.sv
// Key event controller: one key_track per key feeds a one-deep pending slot;
// full slots are granted round-robin into a single valid/ready output register.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   key_level  : debounced key levels, 1 = pressed
//   evt_valid  : output event valid
//   evt_ready  : consumer accepts the event
//   evt_key    : index of the key that raised the event
//   evt_type   : PRESS=0, RELEASE=1, LONG=2, REPEAT=3
//   overrun    : sticky, an event was dropped because its slot was full
module key_event_ctrl
  import key_evt_pkg::*;
#(
  parameter int unsigned NUM_KEYS      = 4,
  parameter int unsigned LONG_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000,
  localparam int unsigned KEY_W        = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_level,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [KEY_W-1:0]    evt_key,
  output logic [1:0]          evt_type,
  output logic                overrun
);

  localparam int unsigned CNT_W = cnt_width(LONG_CYCLES, REPEAT_CYCLES);

  logic [NUM_KEYS-1:0] w_raise;
  evt_type_e           w_raise_type [NUM_KEYS];
  evt_slot_t           r_slot       [NUM_KEYS];
  logic [NUM_KEYS-1:0] w_gnt;
  logic [NUM_KEYS-1:0] w_drop;
  logic [KEY_W-1:0]    w_gnt_idx;
  logic                w_any_full;
  logic                w_out_load;
  logic [KEY_W-1:0]    r_ptr;
  logic                r_evt_valid;
  logic [KEY_W-1:0]    r_evt_key;
  evt_type_e           r_evt_type;
  logic                r_overrun;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_trk
    key_track #(
      .LONG_CYCLES  (LONG_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES),
      .CNT_W        (CNT_W)
    ) u_trk (
      .clk        (clk),
      .rst        (rst),
      .i_key_level(key_level[g]),
      .o_raise    (w_raise[g]),
      .o_type     (w_raise_type[g])
    );
  end

  // Output register can take a new event when empty or being drained
  assign w_out_load = ~r_evt_valid | evt_ready;

  // Round-robin search starting one past the last granted key
  always_comb begin : p_arb
    int unsigned idx;
    idx        = 0;
    w_any_full = 1'b0;
    w_gnt_idx  = r_ptr;
    w_gnt      = '0;
    for (int unsigned off = 1; off <= NUM_KEYS; off++) begin
      idx = (32'(r_ptr) + off) % NUM_KEYS;
      if (!w_any_full && r_slot[idx].valid) begin
        w_any_full = 1'b1;
        w_gnt_idx  = KEY_W'(idx);
      end
    end
    if (w_any_full && w_out_load) begin
      w_gnt[w_gnt_idx] = 1'b1;
    end
  end

  // A new event is lost only if its slot stays occupied this cycle
  always_comb begin
    w_drop = '0;
    for (int unsigned k = 0; k < NUM_KEYS; k++) begin
      w_drop[k] = w_raise[k] & r_slot[k].valid & ~w_gnt[k];
    end
  end

  // Pending slots, output register, pointer and overrun flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_evt_valid <= 1'b0;
      r_evt_key   <= '0;
      r_evt_type  <= EVT_PRESS;
      r_overrun   <= 1'b0;
      r_ptr       <= '0;
      for (int unsigned k = 0; k < NUM_KEYS; k++) begin
        r_slot[k] <= '0;
      end
    end else begin
      if (w_out_load) begin
        r_evt_valid <= w_any_full;
        if (w_any_full) begin
          r_evt_key  <= w_gnt_idx;
          r_evt_type <= r_slot[w_gnt_idx].typ;
          r_ptr      <= w_gnt_idx;
        end
      end
      for (int unsigned k = 0; k < NUM_KEYS; k++) begin
        if (w_raise[k] && (!r_slot[k].valid || w_gnt[k])) begin
          r_slot[k] <= '{valid: 1'b1, typ: w_raise_type[k]};
        end else if (w_gnt[k]) begin
          r_slot[k].valid <= 1'b0;
        end
      end
      if (|w_drop) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign evt_valid = r_evt_valid;
  assign evt_key   = r_evt_key;
  assign evt_type  = r_evt_type;
  assign overrun   = r_overrun;

endmodule
